beta_operand_stage: RTL and testbench

Decode/operand-fetch stage that sits directly upstream of the Beta ALU. It accepts one Beta ALU-class instruction (OP or OPC) per handshake and reads Ra/Rb from an internal 32×32 register file. It translates the opcode into the 4-bit ALU function code and presents a registered {alu_fn, alu_a, alu_b, rc} bundle to the execute stage. A busy-bit scoreboard stalls read-after-write and write-after-write hazards until the matching writeback arrives; a same-cycle writeback is bypassed.

---
 rtl/beta_pkg.sv | 91 +++++++++
 rtl/beta_operand_stage_if.sv | 36 +++
 rtl/beta_regfile.sv | 60 ++++++
 rtl/beta_operand_stage.sv | 134 +++++++++++++
 tb/tb_beta_operand_stage.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/beta_pkg.sv
`default_nettype none
// ============================================================================
// Module      : beta_pkg
// Description : Opcode, ALU function and instruction-field definitions shared
//               by the Beta operand-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package beta_pkg;

    localparam int unsigned c_xlen    = 32;
    localparam int unsigned c_ragw    = 5;

    // Instruction field positions
    localparam int unsigned c_opc_lsb = 26;
    localparam int unsigned c_rc_lsb  = 21;
    localparam int unsigned c_ra_lsb  = 16;
    localparam int unsigned c_rb_lsb  = 11;
    localparam int unsigned c_lit_w   = 16;

    // Opcode classes: register-register and register-literal
    localparam logic [5:0] c_op_base  = 6'h20;
    localparam logic [5:0] c_opc_base = 6'h30;

    // Per-operation offset k within a class
    localparam logic [3:0] c_k_add   = 4'h0;
    localparam logic [3:0] c_k_sub   = 4'h1;
    localparam logic [3:0] c_k_mul   = 4'h2;
    localparam logic [3:0] c_k_cmpeq = 4'h4;
    localparam logic [3:0] c_k_cmplt = 4'h5;
    localparam logic [3:0] c_k_cmple = 4'h6;
    localparam logic [3:0] c_k_and   = 4'h8;
    localparam logic [3:0] c_k_or    = 4'h9;
    localparam logic [3:0] c_k_xor   = 4'hA;
    localparam logic [3:0] c_k_xnor  = 4'hB;
    localparam logic [3:0] c_k_shl   = 4'hC;
    localparam logic [3:0] c_k_shr   = 4'hD;
    localparam logic [3:0] c_k_sra   = 4'hE;

    // ALU function codes
    localparam logic [3:0] c_alu_add   = 4'b0000;
    localparam logic [3:0] c_alu_sub   = 4'b0001;
    localparam logic [3:0] c_alu_mul   = 4'b0010;
    localparam logic [3:0] c_alu_cmpeq = 4'b0100;
    localparam logic [3:0] c_alu_cmplt = 4'b0101;
    localparam logic [3:0] c_alu_cmple = 4'b0110;
    localparam logic [3:0] c_alu_and   = 4'b1000;
    localparam logic [3:0] c_alu_or    = 4'b1001;
    localparam logic [3:0] c_alu_xor   = 4'b1010;
    localparam logic [3:0] c_alu_xnor  = 4'b1011;
    localparam logic [3:0] c_alu_shl   = 4'b1100;
    localparam logic [3:0] c_alu_shr   = 4'b1101;
    localparam logic [3:0] c_alu_sra   = 4'b1110;

    typedef struct packed {
        logic [3:0]        fn;
        logic [c_xlen-1:0] a;
        logic [c_xlen-1:0] b;
        logic [c_ragw-1:0] rc;
        logic              illegal;
    } bundle_t;

    typedef struct packed {
        logic       legal;
        logic [3:0] fn;
    } fn_dec_t;

    function automatic fn_dec_t f_decode_k(input logic [3:0] k);
        fn_dec_t d;
        d.legal = 1'b1;
        d.fn    = c_alu_add;
        case (k)
            c_k_add:   d.fn = c_alu_add;
            c_k_sub:   d.fn = c_alu_sub;
            c_k_mul:   d.fn = c_alu_mul;
            c_k_cmpeq: d.fn = c_alu_cmpeq;
            c_k_cmplt: d.fn = c_alu_cmplt;
            c_k_cmple: d.fn = c_alu_cmple;
            c_k_and:   d.fn = c_alu_and;
            c_k_or:    d.fn = c_alu_or;
            c_k_xor:   d.fn = c_alu_xor;
            c_k_xnor:  d.fn = c_alu_xnor;
            c_k_shl:   d.fn = c_alu_shl;
            c_k_shr:   d.fn = c_alu_shr;
            c_k_sra:   d.fn = c_alu_sra;
            default:   d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/beta_operand_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : beta_operand_stage_if
// Description : Fetch-side, ALU-side and writeback signals of the Beta
//               operand-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface beta_operand_stage_if;
    import beta_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        alu_fn;
    logic [c_xlen-1:0] alu_a;
    logic [c_xlen-1:0] alu_b;
    logic [4:0]        out_rc;
    logic              out_illegal;
    logic              wb_en;
    logic [4:0]        wb_addr;
    logic [c_xlen-1:0] wb_data;

    modport master (
        output in_valid, in_instr, out_ready, wb_en, wb_addr, wb_data,
        input  in_ready, out_valid, alu_fn, alu_a, alu_b, out_rc, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, out_ready, wb_en, wb_addr, wb_data,
        output in_ready, out_valid, alu_fn, alu_a, alu_b, out_rc, out_illegal
    );

endinterface
`default_nettype wire

// File: rtl/beta_regfile.sv
`default_nettype none
// ============================================================================
// Module      : beta_regfile
// Description : 2-read/1-write register file; top register reads as zero,
//               same-cycle write is forwarded to both read ports.
// Revision    : 1.0 - initial release
// ============================================================================
module beta_regfile
    import beta_pkg::*;
#(
    parameter int NREGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [4:0]        i_waddr,
    input  logic [c_xlen-1:0] i_wdata,
    input  logic [4:0]        i_raddr_a,
    input  logic [4:0]        i_raddr_b,
    output logic [c_xlen-1:0] o_rdata_a,
    output logic [c_xlen-1:0] o_rdata_b
);

    localparam logic [4:0] c_zero_reg = 5'(NREGS - 1);

    logic [c_xlen-1:0] r_regs [NREGS];
    logic              w_wr;

    assign w_wr = i_we && (i_waddr != c_zero_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        o_rdata_a = r_regs[i_raddr_a];
        if (i_raddr_a == c_zero_reg) begin
            o_rdata_a = '0;
        end else if (w_wr && (i_waddr == i_raddr_a)) begin
            o_rdata_a = i_wdata;
        end
    end

    always_comb begin
        o_rdata_b = r_regs[i_raddr_b];
        if (i_raddr_b == c_zero_reg) begin
            o_rdata_b = '0;
        end else if (w_wr && (i_waddr == i_raddr_b)) begin
            o_rdata_b = i_wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/beta_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : beta_operand_stage
// Description : Beta decode/operand-fetch stage with busy-bit hazard
//               scoreboard and a registered bundle toward the ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module beta_operand_stage
    import beta_pkg::*;
#(
    parameter int NREGS = 32
) (
    input  logic                clk,
    input  logic                rst,
    beta_operand_stage_if.slave bus
);

    localparam logic [4:0] c_zero_reg = 5'(NREGS - 1);

    logic [5:0]        w_opcode;
    logic [3:0]        w_k;
    logic [4:0]        w_rc;
    logic [4:0]        w_ra;
    logic [4:0]        w_rb;
    logic [15:0]       w_lit;
    logic              w_is_op;
    logic              w_is_opc;
    fn_dec_t           w_dec;
    logic              w_legal;
    logic [c_xlen-1:0] w_rdata_a;
    logic [c_xlen-1:0] w_rdata_b;
    logic [NREGS-1:0]  w_clr;
    logic [NREGS-1:0]  w_set;
    logic [NREGS-1:0]  w_busy_eff;
    logic              w_hazard;
    logic              w_in_ready;
    logic              w_accept;
    bundle_t           w_bundle;

    logic [NREGS-1:0]  r_busy;
    logic              r_out_valid;
    bundle_t           r_out;

    assign w_opcode = bus.in_instr[c_opc_lsb +: 6];
    assign w_k      = w_opcode[3:0];
    assign w_rc     = bus.in_instr[c_rc_lsb +: 5];
    assign w_ra     = bus.in_instr[c_ra_lsb +: 5];
    assign w_rb     = bus.in_instr[c_rb_lsb +: 5];
    assign w_lit    = bus.in_instr[c_lit_w-1:0];

    assign w_is_op  = (w_opcode[5:4] == c_op_base[5:4]);
    assign w_is_opc = (w_opcode[5:4] == c_opc_base[5:4]);
    assign w_dec    = f_decode_k(w_k);
    assign w_legal  = (w_is_op || w_is_opc) && w_dec.legal;

    beta_regfile #(
        .NREGS(NREGS)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .i_we      (bus.wb_en),
        .i_waddr   (bus.wb_addr),
        .i_wdata   (bus.wb_data),
        .i_raddr_a (w_ra),
        .i_raddr_b (w_rb),
        .o_rdata_a (w_rdata_a),
        .o_rdata_b (w_rdata_b)
    );

    // A writeback landing this cycle already releases its register.
    always_comb begin
        w_clr = '0;
        if (bus.wb_en) begin
            w_clr[bus.wb_addr] = 1'b1;
        end
    end

    assign w_busy_eff = r_busy & ~w_clr;

    assign w_hazard = w_legal &&
                      (w_busy_eff[w_ra] ||
                       (w_is_op && w_busy_eff[w_rb]) ||
                       w_busy_eff[w_rc]);

    assign w_in_ready = !w_hazard && (!r_out_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;

    always_comb begin
        w_set = '0;
        if (w_accept && w_legal && (w_rc != c_zero_reg)) begin
            w_set[w_rc] = 1'b1;
        end
    end

    always_comb begin
        w_bundle.fn      = w_legal ? w_dec.fn : c_alu_add;
        w_bundle.a       = w_rdata_a;
        w_bundle.b       = w_is_opc ? {{(c_xlen-16){w_lit[15]}}, w_lit} : w_rdata_b;
        w_bundle.rc      = w_rc;
        w_bundle.illegal = !w_legal;
    end

    // Set is OR-ed after the clear so a same-index set wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy             <= (r_busy & ~w_clr) | w_set;
            r_busy[c_zero_reg] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out       <= w_bundle;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.alu_fn      = r_out.fn;
    assign bus.alu_a       = r_out.a;
    assign bus.alu_b       = r_out.b;
    assign bus.out_rc      = r_out.rc;
    assign bus.out_illegal = r_out.illegal;

endmodule
`default_nettype wire

// File: tb/tb_beta_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_beta_operand_stage
// Description : Randomised scoreboard bench for the Beta operand-fetch stage
//               against a register/busy-array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_beta_operand_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;

    beta_operand_stage_if bus ();

    beta_operand_stage #(
        .NREGS(32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rc;
        logic        illegal;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_regs [32];
    bit          m_busy [32];
    bit          m_valid;
    int          vectors = 0;
    int          miscompares = 0;

    // ALU code per k; -1 marks an unsupported operation.
    int fn_tab [16] = '{0, 1, 2, -1, 4, 5, 6, -1, 8, 9, 10, 11, 12, 13, 14, -1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] r, input bit we,
                                           input logic [4:0] wa, input logic [31:0] wd);
        if (r == 5'd31) return 32'd0;
        if (we && wa == r) return wd;
        return m_regs[r];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'd0;
            m_busy[i] = 1'b0;
        end
        m_valid = 1'b0;
        q.delete();
    endtask

    task automatic cycle(input bit v, input logic [31:0] ins, input bit ordy,
                         input bit we, input logic [4:0] wa, input logic [31:0] wd);
        logic [5:0] op;
        logic [4:0] ra, rb, rc;
        int         code;
        bit         legal, isc, haz, exp_ready, acc;
        exp_t       e;
        @(posedge clk);
        #1;
        bus.in_valid  = v;
        bus.in_instr  = ins;
        bus.out_ready = ordy;
        bus.wb_en     = we;
        bus.wb_addr   = wa;
        bus.wb_data   = wd;
        #3;
        op    = ins[31:26];
        rc    = ins[25:21];
        ra    = ins[20:16];
        rb    = ins[15:11];
        code  = fn_tab[op[3:0]];
        legal = (op >= 6'h20) && (op <= 6'h3E) && (code >= 0);
        isc   = (op >= 6'h30);
        haz   = legal && ((m_busy[ra] && !(we && wa == ra)) ||
                          (!isc && m_busy[rb] && !(we && wa == rb)) ||
                          (m_busy[rc] && !(we && wa == rc)));
        exp_ready = !haz && (!m_valid || ordy);
        check("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_ready});
        check("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
        acc = v && exp_ready;
        if (acc) begin
            e.illegal = !legal;
            e.fn      = legal ? 4'(code) : 4'd0;
            e.rc      = rc;
            e.a       = m_read(ra, we, wa, wd);
            e.b       = isc ? 32'($signed(ins[15:0])) : m_read(rb, we, wa, wd);
            q.push_back(e);
        end
        if (we && wa != 5'd31) m_regs[wa] = wd;
        if (we) m_busy[wa] = 1'b0;
        if (acc && legal && rc != 5'd31) m_busy[rc] = 1'b1;
        m_valid = acc ? 1'b1 : (ordy ? 1'b0 : m_valid);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_instr = 32'd0;
        bus.out_ready = 1'b0;
        bus.wb_en    = 1'b1;
        bus.wb_addr  = 5'd5;
        bus.wb_data  = 32'hFFFF_FFFF;
        repeat (n) @(posedge clk);
        #1;
        model_clear();
        rst       = 1'b0;
        bus.wb_en = 1'b0;
        #3;
        check("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst alu_fn", {28'd0, bus.alu_fn}, 32'd0);
        check("rst alu_a", bus.alu_a, 32'd0);
        check("rst alu_b", bus.alu_b, 32'd0);
        check("rst out_rc", {27'd0, bus.out_rc}, 32'd0);
        check("rst out_illegal", {31'd0, bus.out_illegal}, 32'd0);
    endtask

    task automatic rand_cycle();
        logic [5:0]  op;
        logic [4:0]  rr [3];
        logic [4:0]  wa;
        logic [31:0] ins;
        int          busy_list[$];
        for (int j = 0; j < 3; j++) begin
            rr[j] = ($urandom_range(0, 7) == 7) ? 5'd31 : 5'($urandom_range(0, 5));
        end
        op  = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'(6'h20 + $urandom_range(0, 31));
        ins = {op, rr[0], rr[1], rr[2], 11'($urandom)};
        for (int i = 0; i < 32; i++) if (m_busy[i]) busy_list.push_back(i);
        if (busy_list.size() > 0 && $urandom_range(0, 3) != 0)
            wa = 5'(busy_list[$urandom_range(0, busy_list.size() - 1)]);
        else
            wa = 5'($urandom);
        cycle($urandom_range(0, 3) != 0, ins, $urandom_range(0, 3) != 0,
              $urandom_range(0, 1) == 1, wa, $urandom);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (q.size() == 0) begin
                check("unexpected bundle", {31'd0, bus.out_valid}, 32'd0);
            end else begin
                check("alu_fn", {28'd0, bus.alu_fn}, {28'd0, q[0].fn});
                check("out_illegal", {31'd0, bus.out_illegal}, {31'd0, q[0].illegal});
                if (!q[0].illegal) begin
                    check("alu_a", bus.alu_a, q[0].a);
                    check("alu_b", bus.alu_b, q[0].b);
                    check("out_rc", {27'd0, bus.out_rc}, {27'd0, q[0].rc});
                end
                if (bus.out_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_instr  = 32'd0;
        bus.out_ready = 1'b0;
        bus.wb_en     = 1'b0;
        bus.wb_addr   = 5'd0;
        bus.wb_data   = 32'd0;
        model_clear();
        do_reset(2);

        cycle(1, 32'h8040_0800, 1, 0, 5'd0, 32'd0);  // ADD R0,R1,R2
        cycle(1, 32'hC03F_0005, 1, 0, 5'd0, 32'd0);  // ADDC R31,5,R1
        cycle(1, 32'hC4DF_FFFF, 1, 0, 5'd0, 32'd0);  // SUBC R31,-1,R6
        cycle(1, 32'hA4FF_F800, 1, 0, 5'd0, 32'd0);  // OR R31,R31,R7
        cycle(1, 32'h8D00_0000, 1, 0, 5'd0, 32'd0);  // opcode 0x23
        cycle(1, 32'h0100_0000, 1, 0, 5'd0, 32'd0);  // opcode 0x00
        cycle(0, 32'd0, 1, 1, 5'd31, 32'hFFFF_FFFF);
        cycle(1, 32'h813F_F800, 1, 0, 5'd0, 32'd0);  // ADD R31,R31,R9
        for (int r = 0; r < 10; r++) cycle(0, 32'd0, 1, 1, 5'(r), 32'd0);

        // RAW: second ADD waits on R3 until its writeback arrives
        cycle(1, 32'h8061_1000, 1, 0, 5'd0, 32'd0);
        repeat (4) cycle(1, 32'h8083_1800, 1, 0, 5'd0, 32'd0);
        cycle(1, 32'h8083_1800, 1, 1, 5'd3, 32'h0000_1234);
        cycle(0, 32'd0, 1, 1, 5'd4, 32'd0);

        // Backpressure: bundle held for three cycles, then replaced
        cycle(1, 32'hC0BF_0007, 0, 0, 5'd0, 32'd0);
        repeat (3) cycle(1, 32'hC0DF_0009, 0, 0, 5'd0, 32'd0);
        cycle(1, 32'hC0DF_0009, 1, 0, 5'd0, 32'd0);

        repeat (4000) rand_cycle();
        do_reset(1);
        repeat (1500) rand_cycle();

        repeat (3) cycle(0, 32'd0, 1, 0, 5'd0, 32'd0);
        @(negedge clk);
        #1;
        check("queue drained", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
